demux_1to4_64bit: RTL and testbench
===================================

Name: demux_1to4_64bit

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart to the 4-to-1 data selector.
- Accepts one 64-bit word per cycle on a valid/ready input stream and steers it, by a per-word select tag, into one of four independent output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake, so a stalled channel blocks only words addressed to it.
- Sits between a shared producer and four consumers; also keeps per-channel delivery counters for debug.

Parameters:
- WIDTH, 64, data word width in bits.
- SEL_WIDTH, 2, width of the select tag.
- NUM_OUT, 4, number of output channels; must equal 1<<SEL_WIDTH.
- CNT_WIDTH, 16, width of each per-channel accept counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all held output words.
- in_data  input  WIDTH  incoming data word.
- in_sel  input  SEL_WIDTH  destination channel for in_data.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept the word this cycle.
- out_data  output  NUM_OUT*WIDTH  flat bus; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  per-channel word valid.
- out_ready  input  NUM_OUT  per-channel consumer ready.
- acc_cnt  output  NUM_OUT*CNT_WIDTH  flat bus; words accepted per channel, channel k at [k*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Reset (async on rst high): all out_valid = 0, all out_data = 0, all acc_cnt = 0. in_ready evaluates from these (1 when flush = 0).
- Per-channel state is one bit, EMPTY (out_valid[k] = 0) or FULL (out_valid[k] = 1).
- in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]).
  - Combinational from in_sel, out_valid and out_ready; no dependency on in_valid.
- An input handshake occurs when in_valid && in_ready.
  - Next cycle: out_data[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - acc_cnt[in_sel] increments by 1 and wraps modulo 2^CNT_WIDTH; no saturation.
- Latency is exactly 1 cycle from input handshake to out_valid. Throughput is 1 word per cycle when consumers are ready, including back-to-back words to the same channel.
- An output handshake on channel k occurs when out_valid[k] && out_ready[k].
  - If no input handshake targets k in the same cycle, channel k goes EMPTY.
  - If an input handshake targets k in the same cycle, channel k stays FULL and loads the new word (drain and fill together, no bubble).
- While out_valid[k] = 1 and out_ready[k] = 0, out_data[k] is held stable.
- When channel k is EMPTY, out_data[k] holds its last value; consumers must ignore it.
- Channels are independent: a stall on channel j never affects in_ready for words tagged for another channel.
- The block does no reordering across the input. A word to a stalled channel blocks the input (head-of-line) until that channel drains.
- flush high:
  - in_ready = 0 that cycle.
  - All out_valid clear on the next edge.
  - out_data and acc_cnt are unchanged.
  - An output handshake occurring in the flush cycle still counts as delivered.
- out_ready[k] asserted while channel k is EMPTY has no effect.
- in_valid low: no state change except drains and flush.
- rst asserted mid-transfer drops all held words immediately; no partial state survives.

Test Plan:
- Reset then idle: rst pulse, all out_ready = 1 -> out_valid = 4'b0000, in_ready = 1, every acc_cnt = 0.
- Single routing: in_sel = 2, in_data = 64'hDEAD_BEEF_0000_0002, one-cycle valid -> next cycle out_valid = 4'b0100, out_data[2] = that word; drained next cycle; acc_cnt[2] = 1, others 0.
- Back-to-back same channel, out_ready[1] = 1: four words 1..4 to sel 1 on consecutive cycles -> out_data[1] shows 1, 2, 3, 4 on consecutive cycles, in_ready stays 1, acc_cnt[1] = 4.
- Backpressure isolation: out_ready[0] = 0, channel 0 FULL with 64'hA; present sel 0 -> in_ready = 0 and out_data[0] stays 64'hA; then present sel 3 -> accepted, out_valid[3] = 1. Raise out_ready[0] -> the sel-0 word is accepted in the same cycle the old word drains.
- Flush: channels 0 and 1 FULL, out_ready = 0, flush pulse with in_valid = 1 -> in_ready = 0 that cycle, next cycle out_valid = 0, acc_cnt unchanged.
- Counter wrap: CNT_WIDTH = 4, 17 words to channel 3 -> acc_cnt[3] = 1.

Source files
------------

// File: rtl/demux_1to4_64bit.sv
// Registered 1-to-N demultiplexer: one valid/ready input stream is steered by a
// per-word tag into N one-entry output channels, each with its own handshake.

module demux_chan #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic                 ready,
  output logic                 valid,
  output logic [WIDTH-1:0]     data,
  output logic [CNT_WIDTH-1:0] cnt
);
  // load never coincides with flush because in_ready is gated by flush upstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      if (load) begin
        data <= din;
        cnt  <= cnt + CNT_WIDTH'(1);
      end
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (ready) valid <= 1'b0;
    end
  end
endmodule

module demux_1to4_64bit #(
  parameter int WIDTH     = 64,
  parameter int SEL_WIDTH = 2,
  parameter int NUM_OUT   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [SEL_WIDTH-1:0]           in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_OUT*WIDTH-1:0]       out_data,
  output logic [NUM_OUT-1:0]             out_valid,
  input  logic [NUM_OUT-1:0]             out_ready,
  output logic [NUM_OUT*CNT_WIDTH-1:0]   acc_cnt
);
  logic [NUM_OUT-1:0][WIDTH-1:0]     data_q;
  logic [NUM_OUT-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [NUM_OUT-1:0]                vld_q;
  logic [NUM_OUT-1:0]                load;
  logic                              in_fire;

  // Only the addressed channel gates the input; other stalls are invisible here
  assign in_ready = !flush && (!vld_q[in_sel] || out_ready[in_sel]);
  assign in_fire  = in_valid && in_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
    assign load[k] = in_fire && (in_sel == SEL_WIDTH'(k));
    demux_chan #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (vld_q[k]),
      .data  (data_q[k]),
      .cnt   (cnt_q[k])
    );
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign acc_cnt   = cnt_q;
endmodule

// File: tb/tb_demux_1to4_64bit.sv
// Directed bench for demux_1to4_64bit, built with 4-bit counters so wrap is reachable.

module tb_demux_1to4_64bit;
  localparam int W = 64, SW = 2, N = 4, CW = 4;

  logic            clk, rst, flush;
  logic [W-1:0]    in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid, in_ready;
  logic [N*W-1:0]  out_data;
  logic [N-1:0]    out_valid, out_ready;
  logic [N*CW-1:0] acc_cnt;

  int checks = 0;
  int fails  = 0;

  demux_1to4_64bit #(.WIDTH(W), .SEL_WIDTH(SW), .NUM_OUT(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .acc_cnt(acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] od(input int k);
    return out_data[k*W +: W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
    out_ready = 4'b1111;
    #3;
    checks++;
    if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b exp 0000", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if (acc_cnt !== 16'h0000) begin fails++; $display("FAIL reset_cnt got %h exp 0000", acc_cnt); end
    checks++;
    if (out_data !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", out_data); end
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      fails++; $display("FAIL idle got valid=%b rdy=%b exp 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single;
    in_sel = 2'd2; in_data = 64'hDEAD_BEEF_0000_0002; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL single_rdy got %b exp 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || od(2) !== 64'hDEAD_BEEF_0000_0002) begin
      fails++; $display("FAIL single_out got valid=%b data=%h exp 0100/deadbeef00000002", out_valid, od(2));
    end
    tick;
    checks++;
    if (out_valid !== 4'b0000 || acc_cnt !== 16'h0100) begin
      fails++; $display("FAIL single_drain got valid=%b cnt=%h exp 0000/0100", out_valid, acc_cnt);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) begin
      in_sel = 2'd1; in_data = 64'(i); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy%0d got %b exp 1", i, in_ready); end
      tick;
      checks++;
      if (out_valid[1] !== 1'b1 || od(1) !== 64'(i)) begin
        fails++; $display("FAIL b2b_word%0d got valid=%b data=%h exp 1/%h", i, out_valid[1], od(1), 64'(i));
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 4'b0000 || acc_cnt !== 16'h0140) begin
      fails++; $display("FAIL b2b_cnt got valid=%b cnt=%h exp 0000/0140", out_valid, acc_cnt);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 4'b1110;
    in_sel = 2'd0; in_data = 64'hA; in_valid = 1'b1;
    tick;
    in_data = 64'hB;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_block got %b exp 0", in_ready); end
    tick;
    checks++;
    if (out_valid[0] !== 1'b1 || od(0) !== 64'hA) begin
      fails++; $display("FAIL bp_hold got valid=%b data=%h exp 1/a", out_valid[0], od(0));
    end
    in_sel = 2'd3; in_data = 64'hC;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_other_rdy got %b exp 1", in_ready); end
    tick;
    checks++;
    if (out_valid !== 4'b1001 || od(3) !== 64'hC || od(0) !== 64'hA) begin
      fails++; $display("FAIL bp_other got valid=%b d3=%h d0=%h exp 1001/c/a", out_valid, od(3), od(0));
    end
    in_sel = 2'd0; in_data = 64'hB; out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b exp 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || od(0) !== 64'hB) begin
      fails++; $display("FAIL bp_refill got valid=%b data=%h exp 0001/b", out_valid, od(0));
    end
    tick;
    checks++;
    if (out_valid !== 4'b0000 || acc_cnt !== 16'h1142) begin
      fails++; $display("FAIL bp_cnt got valid=%b cnt=%h exp 0000/1142", out_valid, acc_cnt);
    end
  endtask

  task automatic test_flush;
    out_ready = 4'b0000;
    in_sel = 2'd0; in_data = 64'hD0; in_valid = 1'b1;
    tick;
    in_sel = 2'd1; in_data = 64'hD1;
    tick;
    checks++;
    if (out_valid !== 4'b0011) begin fails++; $display("FAIL flush_pre got %b exp 0011", out_valid); end
    flush = 1'b1; in_sel = 2'd2; in_data = 64'hEE;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_rdy got %b exp 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || acc_cnt !== 16'h1153 || od(0) !== 64'hD0 || od(2) !== 64'hDEAD_BEEF_0000_0002) begin
      fails++; $display("FAIL flush_post got valid=%b cnt=%h d0=%h d2=%h exp 0000/1153/d0/deadbeef00000002",
                        out_valid, acc_cnt, od(0), od(2));
    end
  endtask

  task automatic test_reset_mid;
    in_sel = 2'd0; in_data = 64'h55; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || acc_cnt !== 16'h0000 || out_data !== '0) begin
      fails++; $display("FAIL reset_mid got valid=%b cnt=%h exp 0000/0000", out_valid, acc_cnt);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_wrap;
    int stalls;
    stalls = 0;
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      in_sel = 2'd3; in_data = 64'(100 + i); in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1) stalls++;
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin fails++; $display("FAIL wrap_stalls got %0d exp 0", stalls); end
    checks++;
    if (acc_cnt !== 16'h1000 || od(3) !== 64'd116) begin
      fails++; $display("FAIL wrap_cnt got cnt=%h d3=%h exp 1000/74", acc_cnt, od(3));
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
